// File: rtl/mac_pkg.sv
// mac_pkg -- shared definitions for the MAC accumulator slice.
//   state_t    : accumulator FSM state encoding
//   DEF_*      : default operand width, guard bits and term-counter width
//   acc_width  : accumulator width derived from operand width and guard bits
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEF_N     = 32;
  localparam int DEF_GUARD = 8;
  localparam int DEF_CNT_W = 16;

  // Accumulator holds the full 2N-bit product plus GUARD headroom bits.
  function automatic int acc_width(input int n, input int guard);
    return 2 * n + guard;
  endfunction

endpackage

// File: rtl/mac_ovf_adder.sv
// mac_ovf_adder -- W-bit two's-complement adder with signed overflow flag.
//   i_a, i_b : signed addends (W bits)
//   o_sum    : i_a + i_b, wrapped modulo 2^W
//   o_ovf    : high when both addends share a sign and the sum's sign differs
module mac_ovf_adder #(
  parameter int W = 72
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  assign o_sum = i_a + i_b;
  assign o_ovf = (i_a[W-1] == i_b[W-1]) && (o_sum[W-1] != i_a[W-1]);

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator -- accumulates a stream of signed products into a dot product.
//   clk, rst    : clock and synchronous active-high reset
//   prod_in     : signed 2N-bit product term
//   prod_valid  : prod_in holds a term this cycle
//   prod_last   : the term closes the dot product (qualified by prod_valid)
//   prod_ready  : a term is accepted this cycle when prod_valid is also high
//   acc_out     : signed ACC_W-bit dot product result
//   acc_cnt     : number of terms summed (saturating)
//   acc_ovf     : the running sum wrapped at some point in this dot product
//   acc_valid   : result outputs are valid
//   acc_ready   : downstream accepts the result
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int GUARD = DEF_GUARD,
  parameter int CNT_W = DEF_CNT_W,
  localparam int ACC_W = acc_width(N, GUARD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*N-1:0]   prod_in,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] acc_cnt,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  logic [ACC_W-1:0]  w_term;
  logic [ACC_W-1:0]  w_sum;
  logic              w_ovf;
  logic              w_accept;
  logic              w_load;
  logic              w_add;

  // Sign-extend the product into the accumulator width.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_term = prod_in;
    end else begin : g_guard
      assign w_term = {{GUARD{prod_in[2*N-1]}}, prod_in};
    end
  endgenerate

  mac_ovf_adder #(
    .W(ACC_W)
  ) u_add (
    .i_a  (r_acc),
    .i_b  (w_term),
    .o_sum(w_sum),
    .o_ovf(w_ovf)
  );

  assign w_accept = prod_valid && prod_ready;
  // A term arriving in HOLD is only accepted once the result is handed off,
  // so it always opens a new dot product, exactly like a term in IDLE.
  assign w_load   = w_accept && (r_state == ST_IDLE || r_state == ST_HOLD);
  assign w_add    = w_accept && (r_state == ST_ACCUM);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = prod_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_accept && prod_last) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (acc_ready) begin
          if (w_accept) begin
            w_state_next = prod_last ? ST_HOLD : ST_ACCUM;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic; both handshake outputs are forced low during reset.
  always_comb begin
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE:  prod_ready = 1'b1;
        ST_ACCUM: prod_ready = 1'b1;
        ST_HOLD: begin
          prod_ready = acc_ready;
          acc_valid  = 1'b1;
        end
        default: prod_ready = 1'b0;
      endcase
    end
  end

  // Accumulator, term counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_load) begin
      r_acc <= w_term;
      r_cnt <= CNT_W'(1);
      r_ovf <= 1'b0;
    end else if (w_add) begin
      r_acc <= w_sum;
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_ovf <= r_ovf | w_ovf;
    end
  end

  assign acc_out = r_acc;
  assign acc_cnt = r_cnt;
  assign acc_ovf = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

  localparam int N      = 8;
  localparam int GUARD  = 0;
  localparam int CNT_W  = 4;
  localparam int ACC_W  = 2 * N + GUARD;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2*N-1:0]   prod_in = '0;
  logic             prod_valid = 1'b0;
  logic             prod_last = 1'b0;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_ovf;
  logic             acc_valid;
  logic             acc_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  typedef struct {
    longint sum;
    int     cnt;
    bit     ovf;
  } exp_t;
  exp_t sb[$];

  // Reference model state: running wrapped sum, term count, sticky overflow.
  longint m_sum = 0;
  int     m_n = 0;
  bit     m_ovf = 0;

  mac_accumulator #(
    .N(N), .GUARD(GUARD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_last(prod_last),
    .prod_ready(prod_ready),
    .acc_out(acc_out), .acc_cnt(acc_cnt), .acc_ovf(acc_ovf),
    .acc_valid(acc_valid), .acc_ready(acc_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap_acc(input longint v);
    longint m;
    m = v & ((longint'(1) <<< ACC_W) - 1);
    if (m > ACC_MAX) m = m - (longint'(1) <<< ACC_W);
    return m;
  endfunction

  function automatic void model_reset();
    m_sum = 0;
    m_n = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_term(input int t, input bit last);
    longint exact;
    exp_t e;
    if (m_n == 0) begin
      m_sum = t;
      m_ovf = 0;
      m_n = 1;
    end else begin
      exact = m_sum + t;
      if (exact > ACC_MAX || exact < ACC_MIN) m_ovf = 1;
      m_sum = wrap_acc(exact);
      m_n++;
    end
    if (last) begin
      e.sum = m_sum;
      e.cnt = (m_n > CNT_MAX) ? CNT_MAX : m_n;
      e.ovf = m_ovf;
      sb.push_back(e);
      m_n = 0;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      prod_valid = 1'b0;
      prod_in = 16'($urandom);
      prod_last = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_term(input int t, input bit last);
    bit done = 0;
    prod_valid = 1'b1;
    prod_in = 16'(t);
    prod_last = last;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (prod_ready) done = 1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (done) model_term(t, last);
    prod_valid = 1'b0;
    prod_in = 16'($urandom);
    prod_last = 1'($urandom);
  endtask

  // Downstream ready generator.
  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       acc_ready = 1'b1;
      1:       acc_ready = 1'($urandom_range(0, 3) != 0);
      default: acc_ready = 1'b0;
    endcase
  end

  // Monitor: checks results on handshake, hold stability and result latency.
  logic             prev_hold = 1'b0;
  logic [ACC_W-1:0] prev_out;
  logic [CNT_W-1:0] prev_cnt;
  logic             prev_ovf;
  logic             last_seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hold = 1'b0;
      last_seen = 1'b0;
    end else begin
      if (last_seen) chk("latency_valid", acc_valid, 1);
      if (prev_hold) begin
        chk("hold_valid", acc_valid, 1);
        chk("hold_out", $signed(acc_out), $signed(prev_out));
        chk("hold_cnt", acc_cnt, prev_cnt);
        chk("hold_ovf", acc_ovf, prev_ovf);
      end
      if (acc_valid && acc_ready) begin
        $display("result: out=%0d cnt=%0d ovf=%0d", $signed(acc_out), acc_cnt, acc_ovf);
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("acc_out", $signed(acc_out), e.sum);
          chk("acc_cnt", acc_cnt, e.cnt);
          chk("acc_ovf", acc_ovf, e.ovf);
        end
      end
      prev_hold = acc_valid && !acc_ready;
      prev_out  = acc_out;
      prev_cnt  = acc_cnt;
      prev_ovf  = acc_ovf;
      last_seen = prod_valid && prod_ready && prod_last;
    end
  end

  initial begin
    int len;
    int t;
    logic [15:0] r;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_acc_cnt", acc_cnt, 0);
    chk("rst_acc_ovf", acc_ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", prod_ready, 1);
    @(posedge clk);
    #1;

    // Three-term dot product, single-cycle valid
    send_term(-24, 0);
    send_term(-14, 0);
    send_term(15, 1);
    @(negedge clk);
    chk("dp3_valid", acc_valid, 1);
    chk("dp3_out", $signed(acc_out), -23);
    @(negedge clk);
    chk("dp3_valid_drop", acc_valid, 0);
    @(posedge clk);
    #1;

    // Single term held while downstream stalls
    ready_mode = 2;
    @(posedge clk);
    #1;
    send_term(16129, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", acc_valid, 1);
      chk("stall_prod_ready", prod_ready, 0);
      chk("stall_out", $signed(acc_out), 16129);
    end
    ready_mode = 0;
    repeat (2) @(negedge clk);
    chk("stall_idle_valid", acc_valid, 0);
    chk("stall_idle_ready", prod_ready, 1);
    @(posedge clk);
    #1;

    // Back-to-back dot products with no bubble
    send_term(126, 0);
    send_term(0, 1);
    send_term(-35, 1);
    @(negedge clk);
    chk("b2b_valid", acc_valid, 1);
    chk("b2b_out", $signed(acc_out), -35);
    @(posedge clk);
    #1;

    // Overflow with no guard bits, then cleared on the next dot product
    send_term(32767, 0);
    send_term(32767, 1);
    idle(2);
    send_term(1, 1);
    idle(2);

    // Reset mid-accumulation discards the partial result
    send_term(100, 0);
    send_term(200, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_valid", acc_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_term(7, 0);
    send_term(-2, 1);
    idle(2);

    // Gaps with garbage between terms
    send_term(3, 0);
    idle(4);
    send_term(4, 1);
    idle(3);

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 4; i++) send_term(i, i == CNT_MAX + 3);
    idle(2);

    // Random dot products with random downstream backpressure and gaps
    ready_mode = 1;
    for (int d = 0; d < 40; d++) begin
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) begin
        r = 16'($urandom);
        if ($urandom_range(0, 1) == 0) t = int'($signed(r));
        else t = $urandom_range(0, 400) - 200;
        send_term(t, k == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end

    ready_mode = 0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter N, default 32: multiplier operand width; the product width is 2N.
REQ-002 Parameter GUARD, default 8: accumulator guard bits; ACC_W = 2N+GUARD.
REQ-003 Parameter CNT_W, default 16: term-counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 prod_in  input  2N  signed product from radix4_booth_multiplier Prod.
REQ-007 prod_valid  input  1  prod_in carries a valid term this cycle.
REQ-008 prod_last  input  1  the current term ends the dot product; qualified by prod_valid.
REQ-009 prod_ready  output  1  the block accepts a term this cycle.
REQ-010 acc_out  output  ACC_W  signed accumulated dot product.
REQ-011 acc_cnt  output  CNT_W  number of terms summed into acc_out.
REQ-012 acc_ovf  output  1  the sum overflowed ACC_W during this dot product.
REQ-013 acc_valid  output  1  acc_out, acc_cnt and acc_ovf are valid.
REQ-014 acc_ready  input  1  the downstream consumer accepts the result.

Function
REQ-015 A term is accepted iff prod_valid && prod_ready at a rising clk edge.
REQ-016 The FSM SHALL have three states: IDLE, ACCUM, HOLD.
REQ-017 IDLE: prod_ready=1, acc_valid=0.
- Accepted term: acc <= sign-extended prod_in; cnt <= 1.
- Next state HOLD if prod_last, else ACCUM.
REQ-018 ACCUM: prod_ready=1, acc_valid=0.
- Accepted term: acc <= acc + sext(prod_in); cnt <= cnt+1.
- Next state HOLD if prod_last, else stay in ACCUM.
REQ-019 HOLD: acc_valid=1 and prod_ready=acc_ready; acc_out, acc_cnt and acc_ovf SHALL stay stable until the handshake.
REQ-020 HOLD with acc_ready=1 and no accepted term: next state IDLE.
REQ-021 HOLD with acc_ready=1 and an accepted term: the new term SHALL load as in IDLE (back-to-back, zero bubble); next state HOLD if prod_last, else ACCUM.
REQ-022 acc_valid SHALL assert the cycle after the last term is accepted (latency 1 from the last accepted term).
REQ-023 Addition SHALL wrap modulo 2^ACC_W.
- acc_ovf sets when both operand signs are equal and the result sign differs.
- acc_ovf is sticky until the dot product is handed off, and clears on the first term of the next dot product.
REQ-024 acc_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 prod_in and prod_last SHALL be ignored when prod_valid=0.
REQ-026 A single-term dot product (prod_last on the first term) SHALL yield acc_out = sext(prod_in) and acc_cnt=1.
REQ-027 acc_out and acc_cnt SHALL be driven directly from registers.

Reset
REQ-028 While rst=1, at each clk edge: state <= IDLE; acc, cnt and acc_ovf <= 0.
REQ-029 While rst=1, prod_ready=0 and acc_valid=0.
REQ-030 Reset asserted mid-accumulation or in HOLD SHALL discard the partial or pending result, with no acc_valid pulse.
REQ-031 In the first cycle after rst deasserts, the block SHALL be in IDLE with prod_ready=1.

Structure
REQ-032 A shared package mac_pkg SHALL hold:
- the state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
- default N, GUARD and CNT_W;
- the ACC_W derivation.
REQ-033 One sub-module, mac_ovf_adder (ACC_W-bit signed add with overflow flag), SHALL be instantiated; the FSM, counter and registers stay in mac_accumulator.

Verification
REQ-034 Terms -24, -14, 15 (last on 15), acc_ready=1 -> acc_out=-23, acc_cnt=3, acc_ovf=0, acc_valid high for exactly 1 cycle, starting 1 cycle after the last term.
REQ-035 Single term 16129 with last, acc_ready=0 for 5 cycles -> acc_valid held for 5 cycles, acc_out=16129 stable, prod_ready=0; IDLE after acc_ready=1.
REQ-036 Back-to-back: dot product {126, 0 last} then {-35 last} offered while in HOLD with acc_ready=1 -> results 126 then -35 with no idle cycle between them.
REQ-037 Two terms of 2^(2N-1)-1 with GUARD=0 -> acc_ovf=1, acc_out = wrapped sum (-2); the next dot product starts with acc_ovf=0.
REQ-038 rst pulse after 2 of 4 terms -> no acc_valid; a following {7, -2 last} -> acc_out=5, acc_cnt=2.
REQ-039 Gaps with prod_valid=0 and garbage on prod_in/prod_last between terms -> result unaffected (terms 3, 4 last -> acc_out=7).
